cavlc_coeff_reader: RTL
=======================

Name: cavlc_coeff_reader

Overview:
- 16-entry coefficient block buffer for the CAVLC path.
- The write side loads one 4x4 block in zigzag order, index 0 to 15, using an up-counting write index.
- The read side then reads the block back in reverse scan order, index 15 down to 0, using a down-counting read index. Reverse order is the order CAVLC level/run coding consumes.
- The block also produces the TotalCoeff count for the block.

Parameters:
- COEF_W, 16, width of one signed coefficient in bits.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  a coefficient is presented on in_coef.
- in_ready  output  1  the block can accept a coefficient (high in LOAD state).
- in_coef  input  COEF_W  signed coefficient, zigzag order.
- out_valid  output  1  out_coef, out_idx and out_last are valid.
- out_ready  input  1  downstream accepts the current output.
- out_coef  output  COEF_W  coefficient at out_idx.
- out_idx  output  4  zigzag index of out_coef.
- out_last  output  1  high on the final output of the block.
- total_coeff  output  5  number of nonzero coefficients in the block, 0..16.
- busy  output  1  high while in READ state.
- blk_empty  output  1  one-cycle pulse when an all-zero block is dropped (feature only; tied 0 otherwise).

Behaviour:
- States: LOAD and READ. On rst: state=LOAD, wr_cnt=0, rd_idx=0, total_coeff=0, out_valid=0, out_last=0, busy=0, blk_empty=0. The coefficient array is not reset.
- rst mid-block, in either state: the partial block is discarded and the next accepted input is index 0.
- LOAD state:
  - in_ready=1, out_valid=0.
  - An accept is in_valid && in_ready. On accept: mem[wr_cnt]<=in_coef and wr_cnt<=wr_cnt+1 (4-bit, wraps 15->0).
  - On the accept at wr_cnt==0: total_coeff<=(in_coef!=0). On later accepts: total_coeff increments when in_coef!=0.
  - last_nz<=wr_cnt whenever in_coef!=0. last_nz is cleared at the wr_cnt==0 accept, before this update is applied.
  - On the accept at wr_cnt==15: go to READ next cycle with rd_idx<=15.
  - in_valid low stalls loading; no state changes.
- READ state:
  - in_ready=0, busy=1, out_valid=1.
  - out_coef=mem[rd_idx] (combinational read of the array), out_idx=rd_idx, out_last=(rd_idx==0).
  - A transfer is out_valid && out_ready.
  - On transfer with rd_idx!=0: rd_idx<=rd_idx-1.
  - On transfer with rd_idx==0: go to LOAD, wr_cnt=0. rd_idx never wraps below 0.
  - out_ready low holds all outputs stable.
- Latency: first out_valid is the cycle after the 16th accept. LOAD resumes (in_ready=1) the cycle after the out_last transfer.
- Throughput: 16 loads plus 16 reads, i.e. 32 cycles per block minimum. No overlap between blocks.
- total_coeff is stable from entry to READ until the first accept of the next block.
- Simultaneous in_valid and READ: input is ignored because in_ready=0; the upstream must hold it.

Optional Feature:
- Macro: CAVLC_SKIP_TRAILING_ZEROS_EN.
- Defined:
  - On entry to READ, rd_idx<=last_nz instead of 15, so the zeros after the highest nonzero index are never emitted.
  - If total_coeff==0 at the 16th accept: no READ state. blk_empty pulses 1 for one cycle, the state stays LOAD, and in_ready stays 1.
- Undefined: the read always starts at 15, all 16 coefficients are emitted, and blk_empty is tied 0.

Test Plan:
- rst, then load coefficients 1..16 (in_coef=idx+1) with out_ready=1 held:
  - out_idx sequence is 15..0 and out_coef is 16..1.
  - out_last is high only at idx 0.
  - total_coeff=16, and 32 cycles per block.
- Load a block of [3,0,-1,0,0,1, then ten zeros]:
  - total_coeff=3.
  - Without the feature, 16 outputs start at idx 15 with value 0.
  - With the feature, outputs are idx5=1, idx4=0, idx3=0, idx2=-1, idx1=0, idx0=3.
- All-zero block:
  - Without the feature: 16 zero outputs, total_coeff=0.
  - With the feature: blk_empty is high for exactly 1 cycle, no out_valid, and in_ready stays 1.
- Backpressure: toggle out_ready 1,0,0,1 in READ.
  - out_coef and out_idx hold while out_ready=0.
  - No index is skipped or repeated.
  - in_valid stays high throughout READ with no data accepted.
- Assert rst after 7 inputs, then load a full new block:
  - The output corresponds only to the new block.
  - total_coeff excludes the first 7 coefficients.
- Gapped input (in_valid 1,0,1,0 ...):
  - Each coefficient is stored exactly once.
  - The READ transition occurs only after the 16th accept.

Source files
------------

// File: rtl/cavlc_coeff_reader.sv
// rtl/cavlc_coeff_reader.sv - 16-entry CAVLC coefficient buffer: zigzag load, reverse-scan read, TotalCoeff.
// Optional: CAVLC_SKIP_TRAILING_ZEROS_EN starts the read at the highest nonzero index and drops all-zero blocks.
module cavlc_coeff_reader #(
  parameter int COEF_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [COEF_W-1:0] out_coef,
  output logic [3:0]               out_idx,
  output logic                     out_last,
  output logic [4:0]               total_coeff,
  output logic                     busy,
  output logic                     blk_empty
);

  typedef enum logic {LOAD, READ} state_t;

  state_t                   state;
  logic [3:0]               wr_cnt;
  logic [3:0]               rd_idx;
  logic signed [COEF_W-1:0] mem [16];
  logic                     accept;
  logic                     xfer;
  logic                     nz;
  logic [4:0]               total_next;
  logic [3:0]               start_idx;
  logic                     drop;

  assign accept     = in_valid && in_ready;
  assign xfer       = out_valid && out_ready;
  assign nz         = (in_coef != '0);
  // The count restarts on the first coefficient of every block.
  assign total_next = ((wr_cnt == 4'd0) ? 5'd0 : total_coeff) + {4'd0, nz};

`ifdef CAVLC_SKIP_TRAILING_ZEROS_EN
  logic [3:0] last_nz;
  logic [3:0] last_nz_next;

  assign last_nz_next = nz ? wr_cnt : ((wr_cnt == 4'd0) ? 4'd0 : last_nz);
  assign start_idx    = last_nz_next;
  assign drop         = (total_next == 5'd0);
`else
  assign start_idx = 4'd15;
  assign drop      = 1'b0;
  assign blk_empty = 1'b0;
`endif

  assign out_coef = mem[rd_idx];
  assign out_idx  = rd_idx;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_cnt] <= in_coef;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      wr_cnt      <= 4'd0;
      rd_idx      <= 4'd0;
      total_coeff <= 5'd0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
`ifdef CAVLC_SKIP_TRAILING_ZEROS_EN
      last_nz     <= 4'd0;
      blk_empty   <= 1'b0;
`endif
    end else begin
`ifdef CAVLC_SKIP_TRAILING_ZEROS_EN
      blk_empty <= 1'b0;
`endif
      case (state)
        LOAD: begin
          if (accept) begin
            wr_cnt      <= wr_cnt + 4'd1;
            total_coeff <= total_next;
`ifdef CAVLC_SKIP_TRAILING_ZEROS_EN
            last_nz     <= last_nz_next;
            if (wr_cnt == 4'd15 && drop) blk_empty <= 1'b1;
`endif
            if (wr_cnt == 4'd15 && !drop) begin
              state     <= READ;
              rd_idx    <= start_idx;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              busy      <= 1'b1;
              out_last  <= (start_idx == 4'd0);
            end
          end
        end
        READ: begin
          if (xfer) begin
            if (rd_idx != 4'd0) begin
              rd_idx   <= rd_idx - 4'd1;
              out_last <= (rd_idx == 4'd1);
            end else begin
              state     <= LOAD;
              wr_cnt    <= 4'd0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
